// File: rtl/arm_bus_regfile.sv
`default_nettype none
// ============================================================================
// Module      : arm_bus_regfile
// Description : ARM chip-select bus slave. Synchronises the async CS/RS/WS
//               strobes, decodes N_REGS byte-writable registers plus a
//               read-only HW_STATUS word, and answers with OE/DTACK.
//               Define BIU_IRQ_EN to add IRQ_STATUS / IRQ_MASK words and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_bus_regfile #(
    parameter int                ADDR_W      = 24,
    parameter int                DATA_W      = 32,
    parameter int                N_REGS      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic [DATA_W-1:0]        DATA_IN,
    output logic [DATA_W-1:0]        DATA_OUT,
    output logic                     DATA_OE,
    input  logic                     CS_B,
    input  logic                     RS_B,
    input  logic                     WS_B,
    input  logic [DATA_W/8-1:0]      BE_B,
    output logic                     DTACK_B,
    input  logic [DATA_W-1:0]        HW_STATUS,
    output logic [N_REGS*DATA_W-1:0] REG_Q
`ifdef BIU_IRQ_EN
    ,
    input  logic [DATA_W-1:0]        IRQ_SRC,
    output logic                     IRQ
`endif
);

    localparam int                c_nb     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_idx_hw = ADDR_W'(N_REGS);
`ifdef BIU_IRQ_EN
    localparam logic [ADDR_W-1:0] c_idx_status = ADDR_W'(N_REGS + 1);
    localparam logic [ADDR_W-1:0] c_idx_mask   = ADDR_W'(N_REGS + 2);
    localparam logic [ADDR_W-1:0] c_idx_max    = c_idx_mask;
`else
    localparam logic [ADDR_W-1:0] c_idx_max    = c_idx_hw;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rs_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic                   r_rs_d;
    logic                   r_ws_d;
    logic                   r_is_wr;
    logic [DATA_W-1:0]      r_regs [N_REGS];
    logic [DATA_W-1:0]      r_data_out;
    logic                   r_data_oe;
    logic                   r_dtack_b;

    logic                   w_cs_s;
    logic                   w_rs_s;
    logic                   w_ws_s;
    logic                   w_rd_req;
    logic                   w_wr_req;
    logic                   w_release;
    logic [ADDR_W-1:0]      w_offset;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_valid;
    logic                   w_wr_fire;
    logic [DATA_W-1:0]      w_rd_data;

    assign w_cs_s = r_cs_sync[SYNC_STAGES-1];
    assign w_rs_s = r_rs_sync[SYNC_STAGES-1];
    assign w_ws_s = r_ws_sync[SYNC_STAGES-1];

    // A request is a high-to-low transition of a synchronised strobe under CS.
    assign w_rd_req  = r_rs_d & ~w_rs_s & ~w_cs_s;
    assign w_wr_req  = r_ws_d & ~w_ws_s & ~w_cs_s;
    assign w_release = w_cs_s | (r_is_wr ? w_ws_s : w_rs_s);

    assign w_offset  = ADDR - BASE_ADDR;
    assign w_idx     = w_offset >> 2;
    assign w_valid   = (ADDR >= BASE_ADDR) && (w_idx <= c_idx_max);
    assign w_wr_fire = (r_state == S_IDLE) && w_wr_req && w_valid;

`ifdef BIU_IRQ_EN
    logic [DATA_W-1:0] r_irq_status;
    logic [DATA_W-1:0] r_irq_mask;
    logic              r_irq;
    logic [DATA_W-1:0] w_status_clr;
    logic [DATA_W-1:0] w_status_nxt;
    logic [DATA_W-1:0] w_mask_nxt;

    always_comb begin
        w_status_clr = '0;
        w_mask_nxt   = r_irq_mask;
        for (int b = 0; b < c_nb; b++) begin
            if (!BE_B[b]) begin
                if (w_wr_fire && (w_idx == c_idx_status))
                    w_status_clr[8*b +: 8] = DATA_IN[8*b +: 8];
                if (w_wr_fire && (w_idx == c_idx_mask))
                    w_mask_nxt[8*b +: 8] = DATA_IN[8*b +: 8];
            end
        end
    end

    // Set takes priority over a same-cycle write-1-to-clear.
    assign w_status_nxt = (r_irq_status & ~w_status_clr) | IRQ_SRC;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq_status <= w_status_nxt;
            r_irq_mask   <= w_mask_nxt;
            r_irq        <= |(w_status_nxt & w_mask_nxt);
        end
    end

    assign IRQ = r_irq;
`endif

    always_comb begin
        w_rd_data = '0;
        if (w_valid) begin
            for (int k = 0; k < N_REGS; k++) begin
                if (w_idx == ADDR_W'(k))
                    w_rd_data = r_regs[k];
            end
            if (w_idx == c_idx_hw)
                w_rd_data = HW_STATUS;
`ifdef BIU_IRQ_EN
            if (w_idx == c_idx_status)
                w_rd_data = r_irq_status;
            if (w_idx == c_idx_mask)
                w_rd_data = r_irq_mask;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_REGS; k++)
                r_regs[k] <= '0;
        end else if (w_wr_fire) begin
            for (int k = 0; k < N_REGS; k++) begin
                if (w_idx == ADDR_W'(k)) begin
                    for (int b = 0; b < c_nb; b++) begin
                        if (!BE_B[b])
                            r_regs[k][8*b +: 8] <= DATA_IN[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cs_sync  <= '1;
            r_rs_sync  <= '1;
            r_ws_sync  <= '1;
            r_rs_d     <= 1'b1;
            r_ws_d     <= 1'b1;
            r_is_wr    <= 1'b0;
            r_state    <= S_IDLE;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_dtack_b  <= 1'b1;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], CS_B};
            r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], RS_B};
            r_ws_sync <= {r_ws_sync[SYNC_STAGES-2:0], WS_B};
            r_rs_d    <= w_rs_s;
            r_ws_d    <= w_ws_s;
            case (r_state)
                S_IDLE: begin
                    // Write has priority when both strobes fall together.
                    if (w_wr_req) begin
                        r_state   <= S_WR;
                        r_is_wr   <= 1'b1;
                        r_dtack_b <= 1'b0;
                    end else if (w_rd_req) begin
                        r_state    <= S_RD;
                        r_is_wr    <= 1'b0;
                        r_data_out <= w_rd_data;
                        r_data_oe  <= 1'b1;
                    end
                end
                S_RD: begin
                    r_dtack_b <= 1'b0;
                    r_state   <= S_HOLD;
                end
                S_WR: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_release) begin
                        r_data_oe <= 1'b0;
                        r_dtack_b <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < N_REGS; k++) begin : g_regq
            assign REG_Q[k*DATA_W +: DATA_W] = r_regs[k];
        end
    endgenerate

    assign DATA_OUT = r_data_out;
    assign DATA_OE  = r_data_oe;
    assign DTACK_B  = r_dtack_b;

endmodule
`default_nettype wire

// File: tb/tb_arm_bus_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_bus_regfile
// Description : Self-checking bench for arm_bus_regfile (vector table, corner
//               sequences and random transfers against a word-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_bus_regfile;

    localparam int          N_REGS = 8;
    localparam logic [23:0] BASE   = 24'h000100;

    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        DATA_OE;
    logic        CS_B, RS_B, WS_B;
    logic [3:0]  BE_B;
    logic        DTACK_B;
    logic [31:0] HW_STATUS;
    logic [N_REGS*32-1:0] REG_Q;
`ifdef BIU_IRQ_EN
    logic [31:0] IRQ_SRC;
    logic        IRQ;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mregs [N_REGS];
    logic [31:0] mstatus;
    logic [31:0] mmask;

    always #5 CLK = ~CLK;

    arm_bus_regfile #(
        .ADDR_W(24), .DATA_W(32), .N_REGS(N_REGS), .BASE_ADDR(BASE), .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE), .CS_B(CS_B), .RS_B(RS_B), .WS_B(WS_B), .BE_B(BE_B),
        .DTACK_B(DTACK_B), .HW_STATUS(HW_STATUS), .REG_Q(REG_Q)
`ifdef BIU_IRQ_EN
        , .IRQ_SRC(IRQ_SRC), .IRQ(IRQ)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (!be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bytemask(input logic [3:0] be);
        return merge(32'h0, 32'hFFFF_FFFF, be);
    endfunction

    function automatic int word_index(input logic [23:0] a);
        if (a < BASE) return -1;
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a);
        int idx = word_index(a);
        if (idx >= 0 && idx < N_REGS) return mregs[idx];
        if (idx == N_REGS) return HW_STATUS;
`ifdef BIU_IRQ_EN
        if (idx == N_REGS + 1) return mstatus;
        if (idx == N_REGS + 2) return mmask;
`endif
        return 32'h0;
    endfunction

    task automatic model_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
        int idx = word_index(a);
        if (idx >= 0 && idx < N_REGS) mregs[idx] = merge(mregs[idx], d, be);
`ifdef BIU_IRQ_EN
        if (idx == N_REGS + 1) mstatus = mstatus & ~(d & bytemask(be));
        if (idx == N_REGS + 2) mmask = merge(mmask, d, be);
`endif
    endtask

    task automatic model_clear();
        for (int k = 0; k < N_REGS; k++) mregs[k] = 32'h0;
        mstatus = 32'h0;
        mmask   = 32'h0;
    endtask

    task automatic chk_regs(input string nm);
        for (int k = 0; k < N_REGS; k++) chk(nm, REG_Q[k*32 +: 32], mregs[k]);
    endtask

    // One full bus cycle: strobe(s) low, wait for DTACK, strobes high, wait for release.
    task automatic do_xfer(input bit is_wr, input bit both, input logic [23:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           output logic [31:0] rdata);
        int  n;
        int  oe_cyc;
        bit  any_oe;
        bit  wr_like;
        wr_like = is_wr || both;
        @(negedge CLK);
        ADDR = a; DATA_IN = d; BE_B = be; CS_B = 1'b0;
        if (wr_like) WS_B = 1'b0;
        if (!is_wr || both) RS_B = 1'b0;
        n = 0; oe_cyc = 0; any_oe = 1'b0;
        do begin
            @(posedge CLK); #1; n++;
            if (DATA_OE) any_oe = 1'b1;
            if (DATA_OE && oe_cyc == 0) oe_cyc = n;
        end while (DTACK_B && n < 20);
        chk("ack_latency", n, wr_like ? 3 : 4);
        if (wr_like) begin
            chk("wr_oe_quiet", {31'h0, any_oe}, 32'h0);
        end else begin
            chk("oe_before_ack", oe_cyc, n - 1);
        end
        rdata = DATA_OUT;
        @(negedge CLK);
        RS_B = 1'b1; WS_B = 1'b1; CS_B = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!DTACK_B && n < 20);
        chk("release_latency", n, 3);
        chk("release_oe", {31'h0, DATA_OE}, 32'h0);
    endtask

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          n;

        vecs[0]  = '{1'b1, BASE + 24'h08, 32'hA5A5_1234, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, BASE + 24'h08, 32'h0,         4'b0000, 32'hA5A5_1234};
        vecs[2]  = '{1'b1, BASE + 24'h08, 32'hFFFF_FFFF, 4'b1010, 32'h0};
        vecs[3]  = '{1'b0, BASE + 24'h08, 32'h0,         4'b0000, 32'hA5FF_12FF};
        vecs[4]  = '{1'b0, BASE + 24'h20, 32'h0,         4'b0000, 32'h0000_BEEF};
        vecs[5]  = '{1'b1, BASE + 24'h20, 32'h1234_5678, 4'b0000, 32'h0};
        vecs[6]  = '{1'b0, BASE + 24'h20, 32'h0,         4'b0000, 32'h0000_BEEF};
        vecs[7]  = '{1'b0, BASE + 24'h2C, 32'h0,         4'b0000, 32'h0};
        vecs[8]  = '{1'b1, BASE - 24'h04, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, BASE - 24'h04, 32'h0,         4'b0000, 32'h0};
        vecs[10] = '{1'b1, BASE + 24'h1C, 32'h5A5A_5A5A, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, BASE + 24'h1F, 32'h0,         4'b0000, 32'h5A5A_5A5A};

        RST = 1'b1; ADDR = '0; DATA_IN = '0; CS_B = 1'b1; RS_B = 1'b1; WS_B = 1'b1;
        BE_B = 4'hF; HW_STATUS = 32'h0000_BEEF;
`ifdef BIU_IRQ_EN
        IRQ_SRC = '0;
`endif
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dtack", {31'h0, DTACK_B}, 32'h1);
        chk("rst_oe", {31'h0, DATA_OE}, 32'h0);
        chk("rst_dout", DATA_OUT, 32'h0);
        chk_regs("rst_regq");
        @(negedge CLK) RST = 1'b0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 12; i++) begin
            do_xfer(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].be, rd);
            if (vecs[i].wr) begin
                model_write(vecs[i].addr, vecs[i].data, vecs[i].be);
                chk_regs("tbl_regq");
            end else begin
                chk("tbl_read", rd, vecs[i].exp);
            end
        end

        // Both strobes fall together: the write wins and the bus is never driven.
        do_xfer(1'b0, 1'b1, BASE, 32'h0000_0011, 4'b0000, rd);
        model_write(BASE, 32'h0000_0011, 4'b0000);
        chk_regs("both_regq");
        chk("both_reg0", REG_Q[31:0], 32'h0000_0011);

        // Reset in the middle of a read, strobes left low afterwards.
        @(negedge CLK);
        ADDR = BASE + 24'h08; CS_B = 1'b0; RS_B = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!DATA_OE && n < 20);
        chk("midrst_oe_pre", {31'h0, DATA_OE}, 32'h1);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_oe", {31'h0, DATA_OE}, 32'h0);
        chk("midrst_dtack", {31'h0, DTACK_B}, 32'h1);
        chk("midrst_dout", DATA_OUT, 32'h0);
        model_clear();
        chk_regs("midrst_regq");
        @(negedge CLK) RST = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (DTACK_B && n < 20);
        chk("midrst_relaunch", n, 4);
        chk("midrst_rdata", DATA_OUT, 32'h0);
        @(negedge CLK);
        RS_B = 1'b1; CS_B = 1'b1;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!DTACK_B && n < 20);
        chk("midrst_release", n, 3);
        repeat (6) @(posedge CLK);
        #1;
        chk("midrst_no_second", {31'h0, DTACK_B}, 32'h1);

        for (int i = 0; i < 150; i++) begin
            logic [23:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            bit          wr;
            logic [31:0] exp;
            wr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0)
                a = 24'($urandom_range(0, int'(BASE) - 1));
            else
                a = BASE + 24'(4 * $urandom_range(0, N_REGS + 3)) + 24'($urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            HW_STATUS = $urandom;
            exp = model_read(a);
            do_xfer(wr, 1'b0, a, d, be, rd);
            if (wr) begin
                model_write(a, d, be);
                chk_regs("rnd_regq");
            end else begin
                chk("rnd_read", rd, exp);
            end
        end

`ifdef BIU_IRQ_EN
        do_xfer(1'b1, 1'b0, BASE + 24'(4 * (N_REGS + 1)), 32'hFFFF_FFFF, 4'b0000, rd);
        do_xfer(1'b1, 1'b0, BASE + 24'(4 * (N_REGS + 2)), 32'h0000_0001, 4'b0000, rd);
        @(negedge CLK) IRQ_SRC = 32'h1;
        @(negedge CLK) IRQ_SRC = 32'h0;
        @(posedge CLK); #1;
        chk("irq_set", {31'h0, IRQ}, 32'h1);
        do_xfer(1'b0, 1'b0, BASE + 24'(4 * (N_REGS + 1)), 32'h0, 4'b0000, rd);
        chk("irq_status_rd", rd, 32'h1);
        do_xfer(1'b1, 1'b0, BASE + 24'(4 * (N_REGS + 1)), 32'h0000_0001, 4'b0000, rd);
        chk("irq_clear", {31'h0, IRQ}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
